// File: rtl/rle_ctrl_pkg.sv
// Shared types and defaults for the rle_enc capture controller.
package rle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_SAMPLING = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int CNT_W_DEF        = 16;
    localparam int FLUSH_CYCLES_DEF = 4;

endpackage

// File: rtl/rle_capture_ctrl_if.sv
// Command/status bundle between trigger logic, rle_enc and the capture controller.
// Optional macro RLE_CTRL_ABORT_EN adds the abort request.
interface rle_capture_ctrl_if
    import rle_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             arm_cmd;
    logic             trigger;
    logic             rle_cfg;
    logic [CNT_W-1:0] stop_count;
    logic             rle_valid_out;
`ifdef RLE_CTRL_ABORT_EN
    logic             abort;
`endif
    logic             rle_enable;
    logic             rle_arm;
    logic             mem_write;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] words_stored;

    modport master (
        output arm_cmd, trigger, rle_cfg, stop_count, rle_valid_out,
`ifdef RLE_CTRL_ABORT_EN
        output abort,
`endif
        input  rle_enable, rle_arm, mem_write, busy, done, words_stored
    );

    modport slave (
        input  arm_cmd, trigger, rle_cfg, stop_count, rle_valid_out,
`ifdef RLE_CTRL_ABORT_EN
        input  abort,
`endif
        output rle_enable, rle_arm, mem_write, busy, done, words_stored
    );
endinterface

// File: rtl/rle_word_counter.sv
// Saturating post-trigger word counter; hit flags the increment that lands on target.
module rle_word_counter
    import rle_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             hit
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_plus1_s;
    logic             sat_s;

    // Next-count arithmetic and terminal compare
    always_comb begin
        count_plus1_s = count_r + ONE;
        sat_s         = (count_r == MAX);
        if (inc && !sat_s) begin
            hit = (count_plus1_s == target);
        end else begin
            hit = 1'b0;
        end
    end

    // Count register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && !sat_s) begin
            count_r <= count_plus1_s;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/rle_capture_ctrl.sv
// Capture sequencer for rle_enc: arm, count post-trigger words, flush, signal done.
// Optional macro RLE_CTRL_ABORT_EN: abort from ARMED/SAMPLING ends the capture via FLUSH.
module rle_capture_ctrl
    import rle_ctrl_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               reset,
    rle_capture_ctrl_if.slave  bus
);
    localparam int            FW        = $clog2(FLUSH_CYCLES);
    localparam logic [FW-1:0] FLUSH_ONE  = FW'(1'b1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_t           state_r, next_state_s;
    logic             cfg_r, cfg_next_s;
    logic [CNT_W-1:0] stop_r;
    logic [FW-1:0]    flush_cnt_r;
    logic             flush_last_s, clear_s, inc_s, hit_s, abort_s, active_next_s;
    logic             rle_enable_r, rle_arm_r, busy_r, done_r;
    logic [CNT_W-1:0] count_s;

`ifdef RLE_CTRL_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    assign clear_s      = (state_r == ST_IDLE) && bus.arm_cmd;
    assign inc_s        = bus.rle_valid_out && ((state_r == ST_SAMPLING) || (state_r == ST_FLUSH));
    assign flush_last_s = (flush_cnt_r == FLUSH_LAST);
    assign cfg_next_s   = clear_s ? bus.rle_cfg : cfg_r;

    rle_word_counter #(.CNT_W(CNT_W)) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_s),
        .inc    (inc_s),
        .target (stop_r),
        .count  (count_s),
        .hit    (hit_s)
    );

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:     next_state_s = bus.arm_cmd ? ST_ARMED : ST_IDLE;
            ST_ARMED: begin
                if (abort_s)          next_state_s = ST_FLUSH;
                else if (bus.trigger) next_state_s = ST_SAMPLING;
                else                  next_state_s = ST_ARMED;
            end
            ST_SAMPLING: begin
                if (abort_s)    next_state_s = ST_FLUSH;
                else if (hit_s) next_state_s = cfg_r ? ST_FLUSH : ST_DONE;
                else            next_state_s = ST_SAMPLING;
            end
            ST_FLUSH:    next_state_s = flush_last_s ? ST_DONE : ST_FLUSH;
            ST_DONE:     next_state_s = ST_IDLE;
            default:     next_state_s = ST_IDLE;
        endcase
        active_next_s = (next_state_s == ST_ARMED) || (next_state_s == ST_SAMPLING);
    end

    // State, latched configuration and flush timer
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cfg_r       <= 1'b0;
            stop_r      <= CNT_W'(1'b1);
            flush_cnt_r <= {FW{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (clear_s) begin
                cfg_r  <= bus.rle_cfg;
                stop_r <= (bus.stop_count == {CNT_W{1'b0}}) ? CNT_W'(1'b1) : bus.stop_count;
            end else begin
                cfg_r  <= cfg_r;
                stop_r <= stop_r;
            end
            if ((state_r == ST_FLUSH) && !flush_last_s) begin
                flush_cnt_r <= flush_cnt_r + FLUSH_ONE;
            end else begin
                flush_cnt_r <= {FW{1'b0}};
            end
        end
    end

    // Registered control outputs, aligned with the state they describe
    always_ff @(posedge clock) begin
        if (reset) begin
            rle_enable_r <= 1'b0;
            rle_arm_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            rle_enable_r <= active_next_s && cfg_next_s;
            rle_arm_r    <= active_next_s;
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (state_r == ST_DONE);
        end
    end

    // Write strobe must track validOut with no added latency
    assign bus.mem_write    = bus.rle_valid_out &&
                              ((state_r == ST_ARMED) || (state_r == ST_SAMPLING) || (state_r == ST_FLUSH));
    assign bus.rle_enable   = rle_enable_r;
    assign bus.rle_arm      = rle_arm_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.words_stored = count_s;
endmodule

// File: tb/tb_rle_capture_ctrl.sv
// Self-checking bench for rle_capture_ctrl with a phase-level reference model.
module tb_rle_capture_ctrl;
    localparam int CNT_W = 16;
    localparam int FC    = 4;
    localparam int MAXC  = 200;

    logic clock = 1'b0;
    logic reset;

    rle_capture_ctrl_if #(.CNT_W(CNT_W)) bus ();

    rle_capture_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(FC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    bit valid_a [MAXC];
    bit trig_a  [MAXC];
    bit abort_a [MAXC];
    bit e_busy  [MAXC];
    bit e_done  [MAXC];
    bit e_en    [MAXC];
    bit e_arm   [MAXC];
    bit e_mw    [MAXC];
    int e_ws    [MAXC];
    int n_cyc;
    int done_cyc;
    int ws_prev = 0;

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            valid_a[i] = 1'b0;
            trig_a[i]  = 1'b0;
            abort_a[i] = 1'b0;
        end
    endtask

    // Cycle 0 carries arm_cmd; the capture walks pre-trigger, counting, optional flush, done.
    task automatic model_capture(input bit cfg, input int stop);
        int stop_eff, cnt, last, c;
        bit counting, flush;
        stop_eff = (stop == 0) ? 1 : stop;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 1'b0; e_done[i] = 1'b0; e_en[i] = 1'b0;
            e_arm[i]  = 1'b0; e_mw[i]   = 1'b0; e_ws[i] = 0;
        end
        e_ws[0]  = ws_prev;
        cnt      = 0;
        counting = 1'b0;
        flush    = cfg;
        last     = -1;
        for (c = 1; c < MAXC - 16 && last < 0; c++) begin
            e_arm[c] = 1'b1; e_en[c] = cfg; e_busy[c] = 1'b1;
            e_mw[c]  = valid_a[c]; e_ws[c] = cnt;
            if (counting && valid_a[c]) cnt++;
            if (abort_a[c]) begin
                last  = c;
                flush = 1'b1;
            end else if (!counting && trig_a[c]) begin
                counting = 1'b1;
            end else if (counting && cnt == stop_eff) begin
                last = c;
            end
        end
        if (last < 0) begin
            failures++;
            $display("FAIL model_end capture never completed within %0d cycles", MAXC);
            last = MAXC - 16;
        end
        c = last + 1;
        if (flush) begin
            for (int k = 0; k < FC; k++) begin
                e_busy[c] = 1'b1; e_mw[c] = valid_a[c]; e_ws[c] = cnt;
                if (valid_a[c] && cnt < 65535) cnt++;
                c++;
            end
        end
        done_cyc     = c;
        e_busy[c]    = 1'b1;
        e_ws[c]      = cnt;
        c++;
        e_done[c]    = 1'b1;
        for (int i = c; i < c + 4; i++) e_ws[i] = cnt;
        n_cyc   = c + 4;
        ws_prev = cnt;
    endtask

    task automatic run_capture(input string name, input bit cfg, input int stop);
        model_capture(cfg, stop);
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clock); #1;
            bus.arm_cmd       = (c == 0) ? 1'b1 : ((c <= done_cyc) ? ($urandom_range(0, 7) == 0) : 1'b0);
            bus.rle_cfg       = (c == 0) ? cfg : 1'($urandom_range(0, 1));
            bus.stop_count    = (c == 0) ? CNT_W'(stop) : CNT_W'($urandom_range(0, 3));
            bus.trigger       = trig_a[c];
            bus.rle_valid_out = valid_a[c];
`ifdef RLE_CTRL_ABORT_EN
            bus.abort         = abort_a[c];
`endif
            @(negedge clock);
            checks += 6;
            if (bus.busy !== e_busy[c]) begin
                failures++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, c, bus.busy, e_busy[c]);
            end
            if (bus.done !== e_done[c]) begin
                failures++; $display("FAIL %s done cyc=%0d got=%b exp=%b", name, c, bus.done, e_done[c]);
            end
            if (bus.rle_enable !== e_en[c]) begin
                failures++; $display("FAIL %s rle_enable cyc=%0d got=%b exp=%b", name, c, bus.rle_enable, e_en[c]);
            end
            if (bus.rle_arm !== e_arm[c]) begin
                failures++; $display("FAIL %s rle_arm cyc=%0d got=%b exp=%b", name, c, bus.rle_arm, e_arm[c]);
            end
            if (bus.mem_write !== e_mw[c]) begin
                failures++; $display("FAIL %s mem_write cyc=%0d got=%b exp=%b", name, c, bus.mem_write, e_mw[c]);
            end
            if (bus.words_stored !== CNT_W'(e_ws[c])) begin
                failures++; $display("FAIL %s words_stored cyc=%0d got=%0d exp=%0d", name, c, bus.words_stored, e_ws[c]);
            end
        end
        @(posedge clock); #1;
        bus.arm_cmd = 1'b0; bus.trigger = 1'b0; bus.rle_valid_out = 1'b0;
`ifdef RLE_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        bus.rle_valid_out = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.rle_enable, bus.rle_arm, bus.mem_write} !== 5'b00000 ||
            bus.words_stored !== {CNT_W{1'b0}}) begin
            failures++;
            $display("FAIL reset outputs got=%b ws=%0d exp=00000 ws=0",
                     {bus.busy, bus.done, bus.rle_enable, bus.rle_arm, bus.mem_write}, bus.words_stored);
        end
        bus.rle_valid_out = 1'b0;
        @(posedge clock); #1;
        reset   = 1'b0;
        ws_prev = 0;
    endtask

    task automatic test_rle_on_basic();
        clear_stim();
        for (int i = 5; i < MAXC; i++) trig_a[i] = 1'b1;
        for (int i = 0; i < MAXC; i++) valid_a[i] = 1'b1;
        run_capture("rle_on_basic", 1'b1, 8);
    endtask

    task automatic test_flush_extra();
        clear_stim();
        for (int i = 2; i < MAXC; i++) trig_a[i] = 1'b1;
        for (int i = 1; i <= 10; i++) valid_a[i] = 1'b1;
        valid_a[12] = 1'b1;
        run_capture("flush_extra", 1'b1, 8);
        checks++;
        if (bus.words_stored !== CNT_W'(9)) begin
            failures++; $display("FAIL flush_extra final words_stored got=%0d exp=9", bus.words_stored);
        end
    endtask

    task automatic test_rle_off();
        clear_stim();
        for (int i = 3; i < MAXC; i++) trig_a[i] = 1'b1;
        for (int i = 0; i < MAXC; i++) valid_a[i] = 1'($urandom_range(0, 1));
        valid_a[6] = 1'b1;
        run_capture("rle_off", 1'b0, 3);
    endtask

    task automatic test_stop_zero();
        clear_stim();
        for (int i = 0; i < MAXC; i++) trig_a[i] = 1'b1;
        for (int i = 0; i < MAXC; i++) valid_a[i] = 1'b1;
        run_capture("stop_zero", 1'b1, 0);
        checks++;
        if (bus.words_stored !== CNT_W'(1 + FC)) begin
            failures++; $display("FAIL stop_zero final words_stored got=%0d exp=%0d", bus.words_stored, 1 + FC);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int tcyc;
            clear_stim();
            tcyc = $urandom_range(1, 10);
            for (int i = tcyc; i < MAXC; i++) trig_a[i] = ($urandom_range(0, 3) != 0) || (i > tcyc + 3);
            for (int i = 0; i < MAXC; i++) valid_a[i] = ($urandom_range(0, 3) != 0);
            run_capture("random", 1'($urandom_range(0, 1)), $urandom_range(0, 20));
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1;
        bus.arm_cmd = 1'b1; bus.rle_cfg = 1'b1; bus.stop_count = CNT_W'(50);
        @(posedge clock); #1;
        bus.arm_cmd = 1'b0; bus.trigger = 1'b1; bus.rle_valid_out = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.words_stored !== CNT_W'(4)) begin
            failures++; $display("FAIL reset_mid pre-reset words_stored got=%0d exp=4", bus.words_stored);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.done, bus.rle_enable, bus.rle_arm, bus.mem_write} !== 5'b00000 ||
            bus.words_stored !== {CNT_W{1'b0}}) begin
            failures++;
            $display("FAIL reset_mid outputs got=%b ws=%0d exp=00000 ws=0",
                     {bus.busy, bus.done, bus.rle_enable, bus.rle_arm, bus.mem_write}, bus.words_stored);
        end
        reset = 1'b0; bus.trigger = 1'b0; bus.rle_valid_out = 1'b0;
        ws_prev = 0;
        clear_stim();
        for (int i = 2; i < MAXC; i++) trig_a[i] = 1'b1;
        for (int i = 0; i < MAXC; i++) valid_a[i] = 1'b1;
        run_capture("reset_mid_rearm", 1'b1, 5);
    endtask

`ifdef RLE_CTRL_ABORT_EN
    task automatic test_abort();
        clear_stim();
        for (int i = 1; i < MAXC; i++) trig_a[i] = 1'b1;
        valid_a[2] = 1'b1; valid_a[3] = 1'b1;
        abort_a[4] = 1'b1;
        for (int i = 5; i < 9; i++) valid_a[i] = 1'($urandom_range(0, 1));
        abort_a[6] = 1'b1;
        run_capture("abort", 1'b1, 100);
        checks++;
        if (bus.words_stored < CNT_W'(2) || bus.words_stored > CNT_W'(2 + FC)) begin
            failures++; $display("FAIL abort final words_stored got=%0d exp=2..%0d", bus.words_stored, 2 + FC);
        end
    endtask
`endif

    initial begin
        reset             = 1'b1;
        bus.arm_cmd       = 1'b0;
        bus.trigger       = 1'b0;
        bus.rle_cfg       = 1'b0;
        bus.stop_count    = {CNT_W{1'b0}};
        bus.rle_valid_out = 1'b0;
`ifdef RLE_CTRL_ABORT_EN
        bus.abort         = 1'b0;
`endif
        test_reset();
        test_rle_on_basic();
        test_flush_extra();
        test_rle_off();
        test_stop_zero();
        test_random();
        test_reset_mid();
`ifdef RLE_CTRL_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
